unidade_controle: RTL and testbench

Multi-cycle control unit and register file that sits directly upstream of the ULA. It fetches 32-bit instructions over a req/ack handshake and decodes them. It drives the ULA operand and opcode inputs from an internal 8×16 register file, writes results back, and resolves branches using the ULA `data_uc` flag. A fetch-to-writeback instruction takes at least four cycles; fetch wait states add to that.

---
 rtl/uc_pkg.sv | 53 +++++
 rtl/unidade_controle_if.sv | 31 +++
 rtl/banco_registradores.sv | 33 +++
 rtl/unidade_controle.sv | 125 ++++++++++++
 tb/tb_unidade_controle.sv | 204 ++++++++++++++++++++
 5 files changed

// File: rtl/uc_pkg.sv
// Opcodes, FSM states and instruction field positions shared by the control unit,
// the ULA and the assembler bench.
package uc_pkg;

    localparam logic [4:0] OP_NOP   = 5'h00;
    localparam logic [4:0] OP_LOADI = 5'h01;
    localparam logic [4:0] OP_MOV   = 5'h02;
    localparam logic [4:0] OP_ADD   = 5'h04;
    localparam logic [4:0] OP_SUB   = 5'h05;
    localparam logic [4:0] OP_AND   = 5'h06;
    localparam logic [4:0] OP_OR    = 5'h07;
    localparam logic [4:0] OP_XOR   = 5'h08;
    localparam logic [4:0] OP_SHL   = 5'h09;
    localparam logic [4:0] OP_SHR   = 5'h0A;
    localparam logic [4:0] OP_INC   = 5'h0B;
    localparam logic [4:0] OP_DEC   = 5'h0C;
    localparam logic [4:0] OP_NOT   = 5'h0D;
    localparam logic [4:0] OP_JMP   = 5'h0E;
    localparam logic [4:0] OP_BZ    = 5'h0F;
    localparam logic [4:0] OP_BNZ   = 5'h10;
    localparam logic [4:0] OP_BLT   = 5'h11;
    localparam logic [4:0] OP_BGT   = 5'h12;
    localparam logic [4:0] OP_BLE   = 5'h13;
    localparam logic [4:0] OP_HALT  = 5'h14;

    typedef enum logic [2:0] {
        FETCH     = 3'd0,
        DECODE    = 3'd1,
        EXECUTE   = 3'd2,
        WRITEBACK = 3'd3,
        HALT      = 3'd4
    } state_t;

    localparam int OPC_MSB = 31;
    localparam int OPC_LSB = 27;
    localparam int RD_MSB  = 26;
    localparam int RD_LSB  = 24;
    localparam int RS_MSB  = 23;
    localparam int RS_LSB  = 21;
    localparam int RT_MSB  = 20;
    localparam int RT_LSB  = 18;
    localparam int IMM_MSB = 15;
    localparam int IMM_LSB = 0;

    function automatic logic op_writes(input logic [4:0] op);
        return (op == OP_LOADI) || (op == OP_MOV) || ((op >= OP_ADD) && (op <= OP_NOT));
    endfunction

    function automatic logic op_is_branch(input logic [4:0] op);
        return (op >= OP_BZ) && (op <= OP_BLE);
    endfunction

endpackage

// File: rtl/unidade_controle_if.sv
// Fetch, ULA and writeback-observation signals of the control unit.
// master = control unit, slave = instruction memory / ULA side.
interface unidade_controle_if #(parameter int PC_W = 8);

    logic            instr_req;
    logic [PC_W-1:0] instr_addr;
    logic            instr_ack;
    logic [31:0]     instr_data;
    logic [15:0]     alu_operando1;
    logic [15:0]     alu_operando2;
    logic [4:0]      alu_opcode;
    logic [31:0]     alu_resultado;
    logic            alu_data_uc;
    logic            wb_en;
    logic [2:0]      wb_addr;
    logic [15:0]     wb_data;
    logic            halted;

    modport master (
        output instr_req, instr_addr, alu_operando1, alu_operando2, alu_opcode,
               wb_en, wb_addr, wb_data, halted,
        input  instr_ack, instr_data, alu_resultado, alu_data_uc
    );

    modport slave (
        input  instr_req, instr_addr, alu_operando1, alu_operando2, alu_opcode,
               wb_en, wb_addr, wb_data, halted,
        output instr_ack, instr_data, alu_resultado, alu_data_uc
    );

endinterface

// File: rtl/banco_registradores.sv
// General register file: async-reset array, two combinational read ports,
// one synchronous write port.
module banco_registradores #(
    parameter int NREG = 8,
    parameter int DW   = 16
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [$clog2(NREG)-1:0] rd_addr_a,
    input  logic [$clog2(NREG)-1:0] rd_addr_b,
    output logic [DW-1:0]           rd_data_a,
    output logic [DW-1:0]           rd_data_b,
    input  logic                    wr_en,
    input  logic [$clog2(NREG)-1:0] wr_addr,
    input  logic [DW-1:0]           wr_data
);

    logic [DW-1:0] regs [NREG];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_en) begin
            regs[wr_addr] <= wr_data;
        end
    end

    assign rd_data_a = regs[rd_addr_a];
    assign rd_data_b = regs[rd_addr_b];

endmodule

// File: rtl/unidade_controle.sv
// Multi-cycle control unit: FETCH/DECODE/EXECUTE/WRITEBACK sequencer driving the ULA,
// four cycles per instruction plus fetch wait states; fetch stalls until instr_ack.
module unidade_controle
    import uc_pkg::*;
#(
    parameter int PC_W = 8,
    parameter int NREG = 8
) (
    input  logic                clock,
    input  logic                reset,
    unidade_controle_if.master  bus
);

    state_t          state;
    logic [PC_W-1:0] pc;
    logic [31:0]     ir;
    logic [15:0]     op1_q;
    logic [15:0]     op2_q;
    logic [4:0]      opc_q;
    logic [15:0]     res_q;
    logic            flag_q;
    logic            halted_q;

    logic [2:0]      ir_rd;
    logic [2:0]      ir_rs;
    logic [2:0]      ir_rt;
    logic [4:0]      ir_op;
    logic [15:0]     ir_imm;
    logic [15:0]     rf_a;
    logic [15:0]     rf_b;
    logic            wb_en_int;
    logic            unused_bits;

    assign ir_op  = ir[OPC_MSB:OPC_LSB];
    assign ir_rd  = ir[RD_MSB:RD_LSB];
    assign ir_rs  = ir[RS_MSB:RS_LSB];
    assign ir_rt  = ir[RT_MSB:RT_LSB];
    assign ir_imm = ir[IMM_MSB:IMM_LSB];

    // Instruction bits [17:16] and the ULA upper result half carry no meaning here.
    assign unused_bits = ^{ir[17:16], bus.alu_resultado[31:16]};

    assign wb_en_int = (state == WRITEBACK) && op_writes(opc_q);

    banco_registradores #(
        .NREG (NREG),
        .DW   (16)
    ) u_banco (
        .clock     (clock),
        .reset     (reset),
        .rd_addr_a (ir_rs),
        .rd_addr_b (ir_rt),
        .rd_data_a (rf_a),
        .rd_data_b (rf_b),
        .wr_en     (wb_en_int),
        .wr_addr   (ir_rd),
        .wr_data   (res_q)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state    <= FETCH;
            pc       <= '0;
            ir       <= '0;
            op1_q    <= '0;
            op2_q    <= '0;
            opc_q    <= '0;
            res_q    <= '0;
            flag_q   <= 1'b0;
            halted_q <= 1'b0;
        end else begin
            case (state)
                FETCH: begin
                    if (bus.instr_ack) begin
                        ir    <= bus.instr_data;
                        state <= DECODE;
                    end
                end
                DECODE: begin
                    op1_q <= rf_a;
                    op2_q <= rf_b;
                    opc_q <= ir_op;
                    state <= EXECUTE;
                end
                EXECUTE: begin
                    // LOADI bypasses the ULA; everything else takes its low half.
                    res_q  <= (opc_q == OP_LOADI) ? ir_imm : bus.alu_resultado[15:0];
                    flag_q <= bus.alu_data_uc;
                    state  <= WRITEBACK;
                end
                WRITEBACK: begin
                    if ((opc_q == OP_JMP) || (op_is_branch(opc_q) && flag_q)) begin
                        pc <= ir_imm[PC_W-1:0];
                    end else begin
                        pc <= pc + PC_W'(1);
                    end
                    if (opc_q == OP_HALT) begin
                        state    <= HALT;
                        halted_q <= 1'b1;
                    end else begin
                        state <= FETCH;
                    end
                end
                HALT: begin
                    state <= HALT;
                end
                default: begin
                    state <= FETCH;
                end
            endcase
        end
    end

    // Gated by reset so the request stays low while reset is held.
    assign bus.instr_req     = (state == FETCH) && !reset;
    assign bus.instr_addr    = pc;
    assign bus.alu_operando1 = op1_q;
    assign bus.alu_operando2 = op2_q;
    assign bus.alu_opcode    = opc_q;
    assign bus.wb_en         = wb_en_int;
    assign bus.wb_addr       = ir_rd;
    assign bus.wb_data       = res_q;
    assign bus.halted        = halted_q;

endmodule

// File: tb/tb_unidade_controle.sv
// Program-table bench for unidade_controle with a behavioural ULA and a writeback scoreboard.
module tb_unidade_controle;
    import uc_pkg::*;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    unidade_controle_if #(.PC_W(8)) bus ();

    unidade_controle #(.PC_W(8), .NREG(8)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    // Behavioural ULA: upper halves carry junk to show they are discarded.
    always_comb begin
        bus.alu_resultado = 32'h0;
        bus.alu_data_uc   = 1'b0;
        case (bus.alu_opcode)
            OP_MOV: bus.alu_resultado = {16'hBEEF, bus.alu_operando1};
            OP_ADD: bus.alu_resultado = {16'h0, bus.alu_operando1} + {16'h0, bus.alu_operando2};
            OP_SUB: bus.alu_resultado = {16'hDEAD, bus.alu_operando1 - bus.alu_operando2};
            OP_BZ:  bus.alu_data_uc   = (bus.alu_operando1 == 16'h0);
            default: ;
        endcase
    end

    typedef struct {
        logic [2:0]  addr;
        logic [15:0] data;
    } wb_t;

    typedef struct {
        logic [7:0]  addr;
        logic [31:0] instr;
        int          waits;
        bit          wb;
        logic [2:0]  wa;
        logic [15:0] wd;
    } row_t;

    wb_t  sb[$];
    row_t prog[13];
    int   passed = 0;
    int   total  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    function automatic logic [31:0] enc(input logic [4:0] op, input logic [2:0] rd,
                                        input logic [2:0] rs, input logic [2:0] rt,
                                        input logic [15:0] imm);
        return {op, rd, rs, rt, 2'b00, imm};
    endfunction

    // Every writeback strobe must match the oldest expected write.
    always @(negedge clock) begin
        if (bus.wb_en) begin
            check("wb_expected", 32'(sb.size() > 0), 32'd1);
            if (sb.size() > 0) begin
                wb_t e;
                e = sb.pop_front();
                check("wb_addr", 32'(bus.wb_addr), 32'(e.addr));
                check("wb_data", 32'(bus.wb_data), 32'(e.data));
            end
        end
    end

    // Waits (bounded) for the request, checks the address, holds off ack, then delivers.
    task automatic fetch(input string tag, input logic [7:0] exp_addr, input logic [31:0] instr,
                         input int waits, output int lat);
        lat = 0;
        while (!bus.instr_req && lat < 20) begin
            @(negedge clock);
            lat++;
        end
        check({tag, "_req"}, 32'(bus.instr_req), 32'd1);
        check({tag, "_addr"}, 32'(bus.instr_addr), 32'(exp_addr));
        for (int w = 0; w < waits; w++) begin
            bus.instr_data = $urandom;
            @(negedge clock);
            check($sformatf("%s_wait%0d_req", tag, w), 32'(bus.instr_req), 32'd1);
            check($sformatf("%s_wait%0d_addr", tag, w), 32'(bus.instr_addr), 32'(exp_addr));
            check($sformatf("%s_wait%0d_wb", tag, w), 32'(bus.wb_en), 32'd0);
        end
        bus.instr_ack  = 1'b1;
        bus.instr_data = instr;
        @(negedge clock);
        bus.instr_ack  = 1'b0;
        bus.instr_data = $urandom;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int lat;

        prog[0]  = '{8'h00, enc(OP_LOADI, 3'd1, 3'd0, 3'd0, 16'd5),      0, 1'b1, 3'd1, 16'h0005};
        prog[1]  = '{8'h01, enc(OP_LOADI, 3'd2, 3'd0, 3'd0, 16'd3),      0, 1'b1, 3'd2, 16'h0003};
        prog[2]  = '{8'h02, enc(OP_ADD,   3'd3, 3'd1, 3'd2, 16'h0),      3, 1'b1, 3'd3, 16'h0008};
        prog[3]  = '{8'h03, enc(OP_SUB,   3'd4, 3'd2, 3'd1, 16'h0),      0, 1'b1, 3'd4, 16'hFFFE};
        prog[4]  = '{8'h04, enc(OP_BZ,    3'd0, 3'd0, 3'd0, 16'h0040),   0, 1'b0, 3'd0, 16'h0};
        prog[5]  = '{8'h40, enc(OP_LOADI, 3'd1, 3'd0, 3'd0, 16'd7),      0, 1'b1, 3'd1, 16'h0007};
        prog[6]  = '{8'h41, enc(OP_BZ,    3'd0, 3'd1, 3'd0, 16'h0010),   0, 1'b0, 3'd0, 16'h0};
        prog[7]  = '{8'h42, enc(OP_JMP,   3'd0, 3'd0, 3'd0, 16'h1234),   0, 1'b0, 3'd0, 16'h0};
        prog[8]  = '{8'h34, enc(OP_JMP,   3'd0, 3'd0, 3'd0, 16'h00FF),   0, 1'b0, 3'd0, 16'h0};
        prog[9]  = '{8'hFF, enc(OP_NOP,   3'd7, 3'd1, 3'd2, 16'h5555),   0, 1'b0, 3'd0, 16'h0};
        prog[10] = '{8'h00, enc(OP_MOV,   3'd5, 3'd3, 3'd0, 16'h0),      0, 1'b1, 3'd5, 16'h0008};
        prog[11] = '{8'h01, enc(5'h03,    3'd6, 3'd1, 3'd2, 16'hAAAA),   0, 1'b0, 3'd0, 16'h0};
        prog[12] = '{8'h02, enc(OP_ADD,   3'd6, 3'd5, 3'd4, 16'h0),      1, 1'b1, 3'd6, 16'h0006};

        reset          = 1'b1;
        bus.instr_ack  = 1'b0;
        bus.instr_data = 32'h0;
        #1;
        check("rst_req",    32'(bus.instr_req), 32'd0);
        check("rst_addr",   32'(bus.instr_addr), 32'd0);
        check("rst_op1",    32'(bus.alu_operando1), 32'd0);
        check("rst_op2",    32'(bus.alu_operando2), 32'd0);
        check("rst_opc",    32'(bus.alu_opcode), 32'd0);
        check("rst_wb_en",  32'(bus.wb_en), 32'd0);
        check("rst_wb_a",   32'(bus.wb_addr), 32'd0);
        check("rst_wb_d",   32'(bus.wb_data), 32'd0);
        check("rst_halted", 32'(bus.halted), 32'd0);
        repeat (2) @(negedge clock);
        reset = 1'b0;
        #1;
        check("first_req", 32'(bus.instr_req), 32'd1);

        for (int i = 0; i < 13; i++) begin
            if (prog[i].wb) sb.push_back('{prog[i].wa, prog[i].wd});
            fetch($sformatf("row%0d", i), prog[i].addr, prog[i].instr, prog[i].waits, lat);
            check($sformatf("row%0d_lat", i), 32'(lat), (i == 0) ? 32'd0 : 32'd3);
        end

        // HALT: halted rises one cycle after WRITEBACK, then acks are ignored.
        fetch("halt", 8'h03, enc(OP_HALT, 3'd0, 3'd0, 3'd0, 16'h0), 0, lat);
        check("halt_lat", 32'(lat), 32'd3);
        repeat (2) @(negedge clock);
        check("halt_wb_stage", 32'(bus.halted), 32'd0);
        @(negedge clock);
        check("halted_set", 32'(bus.halted), 32'd1);
        for (int c = 0; c < 10; c++) begin
            bus.instr_ack  = (c % 2 == 0);
            bus.instr_data = enc(OP_LOADI, 3'd1, 3'd0, 3'd0, 16'h0BAD);
            @(negedge clock);
            check($sformatf("halt_req%0d", c), 32'(bus.instr_req), 32'd0);
            check($sformatf("halt_hold%0d", c), 32'(bus.halted), 32'd1);
        end
        bus.instr_ack = 1'b0;
        check("sb_empty_pre_reset", 32'(sb.size()), 32'd0);

        // Reset out of HALT, then abort an ADD during EXECUTE.
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        sb.push_back('{3'd1, 16'h0005});
        fetch("rs0", 8'h00, enc(OP_LOADI, 3'd1, 3'd0, 3'd0, 16'd5), 0, lat);
        sb.push_back('{3'd2, 16'h0003});
        fetch("rs1", 8'h01, enc(OP_LOADI, 3'd2, 3'd0, 3'd0, 16'd3), 0, lat);
        fetch("rs2", 8'h02, enc(OP_ADD, 3'd3, 3'd1, 3'd2, 16'h0), 0, lat);
        @(negedge clock);
        check("exec_op1", 32'(bus.alu_operando1), 32'h5);
        check("exec_op2", 32'(bus.alu_operando2), 32'h3);
        reset = 1'b1;
        #1;
        check("mid_rst_req",    32'(bus.instr_req), 32'd0);
        check("mid_rst_addr",   32'(bus.instr_addr), 32'd0);
        check("mid_rst_op1",    32'(bus.alu_operando1), 32'd0);
        check("mid_rst_opc",    32'(bus.alu_opcode), 32'd0);
        check("mid_rst_wb_en",  32'(bus.wb_en), 32'd0);
        check("mid_rst_halted", 32'(bus.halted), 32'd0);
        @(negedge clock);
        reset = 1'b0;
        #1;
        check("post_rst_req",  32'(bus.instr_req), 32'd1);
        check("post_rst_addr", 32'(bus.instr_addr), 32'd0);

        // Cleared registers: ADD r3,r1,r2 must see zeros and write zero.
        sb.push_back('{3'd3, 16'h0000});
        fetch("clr", 8'h00, enc(OP_ADD, 3'd3, 3'd1, 3'd2, 16'h0), 0, lat);
        @(negedge clock);
        check("clr_op1", 32'(bus.alu_operando1), 32'd0);
        check("clr_op2", 32'(bus.alu_operando2), 32'd0);
        check("clr_opc", 32'(bus.alu_opcode), 32'(OP_ADD));
        fetch("clr_next", 8'h01, enc(OP_NOP, 3'd0, 3'd0, 3'd0, 16'h0), 0, lat);
        check("clr_next_lat", 32'(lat), 32'd2);
        repeat (4) @(negedge clock);
        check("sb_empty_end", 32'(sb.size()), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
